// File: rtl/iob_cache_ctrl_master.sv
// iob_cache_ctrl_master: sequences cache maintenance commands into control-bus requests.
// Latency: accept -> first ctrl_valid 1 cycle; final ctrl_ready -> done 1 cycle; re-polls add POLL_GAP.
// Backpressure: cmd_ready only in IDLE (no queuing); each request waits for ctrl_ready up to RSP_TIMEOUT.
// Ports: cmd_valid/cmd/cmd_ready command handshake; done/err completion pulse + status;
//        hit_cnt/miss_cnt committed snapshot; ctrl_valid/ctrl_addr/ctrl_rdata/ctrl_ready control bus.

`ifndef CTRL_ADDR_W
`define CTRL_ADDR_W 4
`endif
`ifndef ADDR_BUFFER_EMPTY
`define ADDR_BUFFER_EMPTY 1
`endif
`ifndef ADDR_CACHE_HIT
`define ADDR_CACHE_HIT 3
`endif
`ifndef ADDR_CACHE_MISS
`define ADDR_CACHE_MISS 4
`endif
`ifndef ADDR_RESET_COUNTER
`define ADDR_RESET_COUNTER 9
`endif
`ifndef ADDR_CACHE_INVALIDATE
`define ADDR_CACHE_INVALIDATE 10
`endif

module iob_cache_ctrl_master #(
  parameter int FE_DATA_W   = 32,
  parameter int POLL_MAX    = 256,
  parameter int POLL_GAP    = 4,
  parameter int RSP_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  input  logic [1:0]              cmd,
  output logic                    cmd_ready,
  output logic                    done,
  output logic                    err,
  output logic [FE_DATA_W-1:0]    hit_cnt,
  output logic [FE_DATA_W-1:0]    miss_cnt,
  output logic                    ctrl_valid,
  output logic [`CTRL_ADDR_W-1:0] ctrl_addr,
  input  logic [FE_DATA_W-1:0]    ctrl_rdata,
  input  logic                    ctrl_ready
);

  localparam int AW = `CTRL_ADDR_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] C_FLUSH_INV = 2'd0;
  localparam logic [1:0] C_SNAPSHOT  = 2'd1;
  localparam logic [1:0] C_RESET_CNT = 2'd2;
  localparam logic [1:0] C_DRAIN     = 2'd3;

  localparam logic [15:0] POLL_LIM = 16'(POLL_MAX);
  localparam logic [3:0]  GAP_LAST = 4'(POLL_GAP - 1);
  localparam logic [7:0]  TMO_LAST = 8'(RSP_TIMEOUT - 1);

  // step 0: poll / hit read / reset-counter; step 1: invalidate / miss read
  function automatic logic [AW-1:0] step_addr(input logic [1:0] c, input logic s);
    case (c)
      C_SNAPSHOT:  step_addr = s ? AW'(`ADDR_CACHE_MISS) : AW'(`ADDR_CACHE_HIT);
      C_RESET_CNT: step_addr = AW'(`ADDR_RESET_COUNTER);
      default:     step_addr = s ? AW'(`ADDR_CACHE_INVALIDATE) : AW'(`ADDR_BUFFER_EMPTY);
    endcase
  endfunction

  logic [2:0]           state, state_n;
  logic [1:0]           cmd_r, cmd_n;
  logic                 step, step_n;
  logic [15:0]          poll, poll_n;
  logic [3:0]           gap, gap_n;
  logic [7:0]           tmo, tmo_n;
  logic [FE_DATA_W-1:0] hit_stage, hit_stage_n;
  logic [FE_DATA_W-1:0] miss_stage, miss_stage_n;
  logic [FE_DATA_W-1:0] hit_n, miss_n;
  logic                 err_n;

  assign cmd_ready = (state == S_IDLE);

  always_comb begin
    state_n      = state;
    cmd_n        = cmd_r;
    step_n       = step;
    poll_n       = poll;
    gap_n        = gap;
    tmo_n        = tmo;
    hit_stage_n  = hit_stage;
    miss_stage_n = miss_stage;
    hit_n        = hit_cnt;
    miss_n       = miss_cnt;
    err_n        = err;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_n   = cmd;
          step_n  = 1'b0;
          poll_n  = '0;
          err_n   = 1'b0;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (ctrl_ready) begin
          case (cmd_r)
            C_SNAPSHOT: begin
              if (!step) begin
                hit_stage_n = ctrl_rdata;
                step_n      = 1'b1;
                state_n     = S_ISSUE;
              end else begin
                miss_stage_n = ctrl_rdata;
                hit_n        = hit_stage;
                miss_n       = ctrl_rdata;
                state_n      = S_DONE;
              end
            end
            C_RESET_CNT: state_n = S_DONE;
            default: begin
              if (step) begin
                state_n = S_DONE;
              end else if (ctrl_rdata[0]) begin
                if (cmd_r == C_FLUSH_INV) begin
                  step_n  = 1'b1;
                  state_n = S_ISSUE;
                end else begin
                  state_n = S_DONE;
                end
              end else begin
                poll_n = poll + 16'd1;
                if (poll_n == POLL_LIM) begin
                  err_n   = 1'b1;
                  state_n = S_DONE;
                end else if (POLL_GAP == 0) begin
                  state_n = S_ISSUE;
                end else begin
                  gap_n   = '0;
                  state_n = S_GAP;
                end
              end
            end
          endcase
        end else if (tmo == TMO_LAST) begin
          err_n   = 1'b1;
          state_n = S_DONE;
        end else begin
          tmo_n = tmo + 8'd1;
        end
      end
      S_GAP: begin
        if (gap == GAP_LAST) state_n = S_ISSUE;
        else                 gap_n   = gap + 4'd1;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cmd_r      <= '0;
      step       <= 1'b0;
      poll       <= '0;
      gap        <= '0;
      tmo        <= '0;
      hit_stage  <= '0;
      miss_stage <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      err        <= 1'b0;
      done       <= 1'b0;
      ctrl_valid <= 1'b0;
      ctrl_addr  <= '0;
    end else begin
      state      <= state_n;
      cmd_r      <= cmd_n;
      step       <= step_n;
      poll       <= poll_n;
      gap        <= gap_n;
      tmo        <= tmo_n;
      hit_stage  <= hit_stage_n;
      miss_stage <= miss_stage_n;
      hit_cnt    <= hit_n;
      miss_cnt   <= miss_n;
      err        <= err_n;
      done       <= (state_n == S_DONE);
      ctrl_valid <= (state_n == S_ISSUE);
      if (state_n == S_ISSUE) ctrl_addr <= step_addr(cmd_n, step_n);
    end
  end

endmodule

// File: tb/tb_iob_cache_ctrl_master.sv
// tb_iob_cache_ctrl_master: randomized bench with a timeline model of the control master.
// The model derives per-cycle expected outputs from the command rules and chosen responder latencies.

`ifndef CTRL_ADDR_W
`define CTRL_ADDR_W 4
`endif
`ifndef ADDR_BUFFER_EMPTY
`define ADDR_BUFFER_EMPTY 1
`endif
`ifndef ADDR_CACHE_HIT
`define ADDR_CACHE_HIT 3
`endif
`ifndef ADDR_CACHE_MISS
`define ADDR_CACHE_MISS 4
`endif
`ifndef ADDR_RESET_COUNTER
`define ADDR_RESET_COUNTER 9
`endif
`ifndef ADDR_CACHE_INVALIDATE
`define ADDR_CACHE_INVALIDATE 10
`endif

module tb_iob_cache_ctrl_master;
  localparam int FE_DATA_W   = 32;
  localparam int POLL_MAX    = 5;
  localparam int POLL_GAP    = 4;
  localparam int RSP_TIMEOUT = 15;
  localparam int AW          = `CTRL_ADDR_W;
  localparam int TL          = 128;

  localparam logic [AW-1:0] A_BE   = AW'(`ADDR_BUFFER_EMPTY);
  localparam logic [AW-1:0] A_HIT  = AW'(`ADDR_CACHE_HIT);
  localparam logic [AW-1:0] A_MISS = AW'(`ADDR_CACHE_MISS);
  localparam logic [AW-1:0] A_RST  = AW'(`ADDR_RESET_COUNTER);
  localparam logic [AW-1:0] A_INV  = AW'(`ADDR_CACHE_INVALIDATE);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cmd_valid;
  logic [1:0]           cmd;
  logic                 cmd_ready;
  logic                 done;
  logic                 err;
  logic [FE_DATA_W-1:0] hit_cnt;
  logic [FE_DATA_W-1:0] miss_cnt;
  logic                 ctrl_valid;
  logic [AW-1:0]        ctrl_addr;
  logic [FE_DATA_W-1:0] ctrl_rdata;
  logic                 ctrl_ready;

  iob_cache_ctrl_master #(
    .FE_DATA_W(FE_DATA_W), .POLL_MAX(POLL_MAX), .POLL_GAP(POLL_GAP), .RSP_TIMEOUT(RSP_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .done(done), .err(err), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .ctrl_valid(ctrl_valid), .ctrl_addr(ctrl_addr), .ctrl_rdata(ctrl_rdata), .ctrl_ready(ctrl_ready)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hit  = '0;
  logic [31:0] m_miss = '0;
  logic        m_err  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("idle_ctrl_valid", 32'(ctrl_valid), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_err", 32'(err), 32'(m_err));
      chk("idle_hit", hit_cnt, m_hit);
      chk("idle_miss", miss_cnt, m_miss);
      cmd_valid  = 1'b0;
      cmd        = 2'($urandom);
      ctrl_ready = ($urandom_range(0, 3) == 0);
      ctrl_rdata = $urandom;
    end
  endtask

  // c: 0 FLUSH_INV, 1 SNAPSHOT, 2 RESET_CNT, 3 DRAIN. zeros: poll responses with bit0=0 before a 1.
  // drop: index of the request that never gets a response (-1 none). abort: reset inside the first gap.
  task automatic run_cmd(input logic [1:0] c, input int zeros, input int drop, input bit rand_lat,
                         input bit hold_valid, input logic [31:0] hv, input logic [31:0] mv,
                         input bit abort, output int n_obs, output int done_obs);
    logic [AW-1:0] addrs [0:7];
    logic [31:0]   dat   [0:7];
    int            rt    [0:7];
    bit            ev    [0:TL-1];
    logic [AW-1:0] ea    [0:TL-1];
    bit            rdy   [0:TL-1];
    logic [31:0]   rd    [0:TL-1];
    bit            inw   [0:TL-1];
    int            n, cur, done_t, abort_t, lat;
    bit            e, aborted;
    logic [31:0]   nh, nm;

    for (int i = 0; i < TL; i++) begin
      ev[i] = 0; ea[i] = '0; rdy[i] = 0; rd[i] = '0; inw[i] = 0;
    end
    for (int i = 0; i < 8; i++) begin
      addrs[i] = '0; dat[i] = '0; rt[i] = 0;
    end
    n = 0; e = 0; aborted = 0;

    if (c == 2'd0 || c == 2'd3) begin
      if (zeros >= POLL_MAX) begin n = POLL_MAX; e = 1; end
      else n = zeros + 1;
      for (int i = 0; i < n; i++) begin
        addrs[i]  = A_BE;
        dat[i]    = $urandom;
        dat[i][0] = (i == zeros);
      end
      if (c == 2'd0 && !e) begin
        addrs[n] = A_INV; dat[n] = $urandom; n++;
      end
    end else if (c == 2'd1) begin
      addrs[0] = A_HIT; dat[0] = hv;
      addrs[1] = A_MISS; dat[1] = mv;
      n = 2;
    end else begin
      addrs[0] = A_RST; dat[0] = $urandom;
      n = 1;
    end
    if (drop >= 0 && drop < n) begin n = drop + 1; e = 1; end

    // Timeline: request k issues one cycle after the previous response (plus the gap on a re-poll).
    cur = 1; done_t = 0;
    for (int k = 0; k < n; k++) begin
      ev[cur] = 1; ea[cur] = addrs[k];
      if (k == drop) begin
        for (int w = cur + 1; w <= cur + RSP_TIMEOUT; w++) inw[w] = 1;
        done_t = cur + RSP_TIMEOUT + 1;
      end else begin
        lat   = rand_lat ? int'($urandom_range(1, 3)) : 1;
        rt[k] = cur + lat;
        for (int w = cur + 1; w <= rt[k]; w++) inw[w] = 1;
        rdy[rt[k]] = 1; rd[rt[k]] = dat[k];
        if (k == n - 1) done_t = rt[k] + 1;
        else cur = rt[k] + 1 + ((addrs[k] == A_BE && !dat[k][0]) ? POLL_GAP : 0);
      end
    end
    nh = m_hit; nm = m_miss;
    if (c == 2'd1 && !e) begin nh = hv; nm = mv; end
    abort_t = abort ? rt[0] + 2 : -1;

    n_obs = 0; done_obs = -1;
    for (int t = 0; t <= done_t; t++) begin
      @(negedge clk);
      chk("cmd_ready", 32'(cmd_ready), 32'(t == 0));
      chk("ctrl_valid", 32'(ctrl_valid), 32'(ev[t]));
      if (ev[t]) chk("ctrl_addr", 32'(ctrl_addr), 32'(ea[t]));
      chk("done", 32'(done), 32'(t == done_t));
      chk("err", 32'(err), 32'((t == 0) ? m_err : ((t == done_t) ? e : 1'b0)));
      chk("hit_cnt", hit_cnt, (t == done_t) ? nh : m_hit);
      chk("miss_cnt", miss_cnt, (t == done_t) ? nm : m_miss);
      if (ctrl_valid) n_obs++;
      if (done && done_obs < 0) done_obs = t;
      if (t == abort_t) begin aborted = 1; break; end
      cmd_valid = (t == 0) ? 1'b1 : ((t == done_t) ? 1'b0 : (hold_valid ? 1'b1 : 1'($urandom % 2)));
      cmd       = (t == 0) ? c : 2'($urandom);
      if (rdy[t]) begin
        ctrl_ready = 1'b1; ctrl_rdata = rd[t];
      end else begin
        ctrl_ready = (!inw[t] && t < done_t && $urandom_range(0, 3) == 0);
        ctrl_rdata = $urandom;
      end
    end

    if (aborted) begin
      reset = 1'b1; cmd_valid = 1'b0; ctrl_ready = 1'b0;
      #1;
      chk("rst_ctrl_valid", 32'(ctrl_valid), 32'd0);
      chk("rst_ctrl_addr", 32'(ctrl_addr), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_hit", hit_cnt, 32'd0);
      chk("rst_miss", miss_cnt, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_err = 1'b0; m_hit = '0; m_miss = '0;
    end else begin
      m_err = e; m_hit = nh; m_miss = nm;
    end
    cmd_valid = 1'b0; ctrl_ready = 1'b0;
  endtask

  initial begin
    int nq, dt, zeros, drop;
    logic [1:0] c;
    reset = 1'b1; cmd_valid = 1'b0; cmd = '0; ctrl_rdata = '0; ctrl_ready = 1'b0;
    #2;
    chk("reset_ctrl_valid", 32'(ctrl_valid), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_hit", hit_cnt, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(2);

    // FLUSH_INV with buffer already empty, 1-cycle responder
    run_cmd(2'd0, 0, -1, 0, 0, 0, 0, 0, nq, dt);
    chk("flush_empty_done_t", 32'(dt), 32'd5);
    chk("flush_empty_nreq", 32'(nq), 32'd2);
    idle(1);
    // FLUSH_INV: three empty=0 polls then 1 -> 4 polls + invalidate
    run_cmd(2'd0, 3, -1, 0, 0, 0, 0, 0, nq, dt);
    chk("flush_poll3_nreq", 32'(nq), 32'd5);
    chk("flush_poll3_done_t", 32'(dt), 32'd23);
    chk("flush_poll3_err", 32'(err), 32'd0);
    idle(1);
    // DRAIN never empty -> POLL_MAX polls, err
    run_cmd(2'd3, 99, -1, 0, 0, 0, 0, 0, nq, dt);
    chk("drain_limit_nreq", 32'(nq), 32'd5);
    chk("drain_limit_done_t", 32'(dt), 32'd27);
    idle(2);
    // SNAPSHOT commit, then one with missing MISS response
    run_cmd(2'd1, 0, -1, 0, 0, 32'h0000_0123, 32'h0000_0045, 0, nq, dt);
    chk("snap_done_t", 32'(dt), 32'd5);
    chk("snap_hit", hit_cnt, 32'h0000_0123);
    chk("snap_miss", miss_cnt, 32'h0000_0045);
    run_cmd(2'd1, 0, 1, 0, 0, 32'hdead_beef, 32'hcafe_f00d, 0, nq, dt);
    chk("snap_tmo_done_t", 32'(dt), 32'd19);
    chk("snap_tmo_err", 32'(err), 32'd1);
    chk("snap_tmo_hit", hit_cnt, 32'h0000_0123);
    chk("snap_tmo_miss", miss_cnt, 32'h0000_0045);
    // RESET_CNT with cmd_valid held high throughout
    run_cmd(2'd2, 0, -1, 0, 1, 0, 0, 0, nq, dt);
    chk("rstcnt_done_t", 32'(dt), 32'd3);
    chk("rstcnt_nreq", 32'(nq), 32'd1);
    idle(1);
    // reset during a FLUSH_INV gap, then a normal DRAIN
    run_cmd(2'd0, 3, -1, 0, 0, 0, 0, 1, nq, dt);
    idle(6);
    run_cmd(2'd3, 2, -1, 0, 0, 0, 0, 0, nq, dt);
    chk("drain_after_rst_nreq", 32'(nq), 32'd3);
    chk("drain_after_rst_err", 32'(err), 32'd0);
    idle(1);

    // randomized commands, latencies, drops and stray strobes
    for (int i = 0; i < 60; i++) begin
      c     = 2'($urandom);
      zeros = $urandom_range(0, 6);
      drop  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_cmd(c, zeros, drop, 1, 1'($urandom % 2), $urandom, $urandom, 0, nq, dt);
      idle($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
